apple1_pc_lcd: RTL and testbench

- Downstream consumer of the Apple 1 core's 16-bit pc_monitor output on the Spartan 3E starter kit board.
- Drives the on-board HD44780-compatible character LCD over its 4-bit, write-only interface.
- Runs the LCD power-up/init sequence once, then periodically writes "PC=" followed by the 4-digit uppercase hex PC to line 1.
- Instantiated in the board top beside the core; all timing is derived from clk25.

---
 rtl/apple1_lcd_pkg.sv | 39 +++
 rtl/apple1_lcd_nibble_tx.sv | 77 +++++++
 rtl/apple1_pc_lcd.sv | 217 +++++++++++++++++++++
 tb/tb_apple1_pc_lcd.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/apple1_lcd_pkg.sv
// rtl/apple1_lcd_pkg.sv - shared FSM states, LCD command/character constants and hex encoder
package apple1_lcd_pkg;

    // Top-level sequencer states
    typedef logic [3:0] lcd_state_t;
    localparam lcd_state_t ST_PWRUP      = 4'd0;
    localparam lcd_state_t ST_INIT_A     = 4'd1;
    localparam lcd_state_t ST_INIT_B     = 4'd2;
    localparam lcd_state_t ST_INIT_C     = 4'd3;
    localparam lcd_state_t ST_INIT_D     = 4'd4;
    localparam lcd_state_t ST_CFG        = 4'd5;
    localparam lcd_state_t ST_CLR_WAIT   = 4'd6;
    localparam lcd_state_t ST_FRAME_ADDR = 4'd7;
    localparam lcd_state_t ST_FRAME_CHAR = 4'd8;
    localparam lcd_state_t ST_IDLE       = 4'd9;

    // HD44780 commands
    localparam logic [7:0] FUNC_SET_4BIT = 8'h28;
    localparam logic [7:0] ENTRY_MODE    = 8'h06;
    localparam logic [7:0] DISP_ON       = 8'h0C;
    localparam logic [7:0] CLEAR         = 8'h01;
    localparam logic [7:0] DDRAM_LINE1   = 8'h80;

    // Fixed prefix characters of the "PC=" label
    localparam logic [7:0] CHAR_P  = 8'h50;
    localparam logic [7:0] CHAR_C  = 8'h43;
    localparam logic [7:0] CHAR_EQ = 8'h3D;

    // Uppercase ASCII for one hex digit
    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    // Used to size counters from the largest cycle parameter
    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/apple1_lcd_nibble_tx.sv
// rtl/apple1_lcd_nibble_tx.sv - one 4-bit LCD write: setup, E strobe, done pulse
module apple1_lcd_nibble_tx
    import apple1_lcd_pkg::*;
#(
    parameter int SETUP_CYCLES   = 2,
    parameter int E_PULSE_CYCLES = 12
) (
    input  logic       clk25,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] nibble,
    input  logic       rs,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic [3:0] lcd_d,
    output logic       done
);

    localparam int CNT_W = $clog2(max_u(max_u(SETUP_CYCLES, E_PULSE_CYCLES), 1) + 1);

    localparam logic [1:0] TX_IDLE  = 2'd0;
    localparam logic [1:0] TX_SETUP = 2'd1;
    localparam logic [1:0] TX_HIGH  = 2'd2;

    logic [1:0]       phase;
    logic [CNT_W-1:0] cnt;

    // Data/rs only change when idle, so E is never high while they move
    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            phase  <= TX_IDLE;
            cnt    <= '0;
            lcd_e  <= 1'b0;
            lcd_rs <= 1'b0;
            lcd_d  <= 4'h0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (phase)
                TX_IDLE: begin
                    if (start) begin
                        lcd_d  <= nibble;
                        lcd_rs <= rs;
                        cnt    <= '0;
                        if (SETUP_CYCLES == 0) begin
                            lcd_e <= 1'b1;
                            phase <= TX_HIGH;
                        end else begin
                            phase <= TX_SETUP;
                        end
                    end
                end
                TX_SETUP: begin
                    if (int'(cnt) + 1 >= SETUP_CYCLES) begin
                        lcd_e <= 1'b1;
                        cnt   <= '0;
                        phase <= TX_HIGH;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                TX_HIGH: begin
                    if (int'(cnt) + 1 >= E_PULSE_CYCLES) begin
                        lcd_e <= 1'b0;
                        done  <= 1'b1;
                        cnt   <= '0;
                        phase <= TX_IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: phase <= TX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/apple1_pc_lcd.sv
// rtl/apple1_pc_lcd.sv - shows the Apple 1 program counter as "PC=XXXX" on the character LCD
module apple1_pc_lcd
    import apple1_lcd_pkg::*;
#(
    parameter int POWERUP_CYCLES    = 375000,
    parameter int INIT_WAIT1_CYCLES = 102500,
    parameter int INIT_WAIT2_CYCLES = 2500,
    parameter int SETUP_CYCLES      = 2,
    parameter int E_PULSE_CYCLES    = 12,
    parameter int NIBBLE_GAP_CYCLES = 25,
    parameter int BYTE_WAIT_CYCLES  = 1000,
    parameter int CLEAR_WAIT_CYCLES = 41000,
    parameter int REFRESH_CYCLES    = 2500000
) (
    input  logic        clk25,
    input  logic        rst_n,
    input  logic [15:0] pc_in,
    output logic        lcd_e,
    output logic        lcd_rs,
    output logic        lcd_rw,
    output logic [3:0]  lcd_d,
    output logic        init_done
);

    localparam int unsigned WAIT_MAX =
        max_u(max_u(max_u(POWERUP_CYCLES, INIT_WAIT1_CYCLES), max_u(INIT_WAIT2_CYCLES, BYTE_WAIT_CYCLES)),
              max_u(max_u(CLEAR_WAIT_CYCLES, REFRESH_CYCLES), max_u(NIBBLE_GAP_CYCLES, 1)));
    localparam int WAIT_W = $clog2(WAIT_MAX + 1);

    // Per-transfer sub-sequence: issue nibble, await done, gap or post-wait
    localparam logic [1:0] SUB_START = 2'd0;
    localparam logic [1:0] SUB_BUSY  = 2'd1;
    localparam logic [1:0] SUB_GAP   = 2'd2;
    localparam logic [1:0] SUB_POST  = 2'd3;

    lcd_state_t        state, next_state;
    logic [1:0]        sub;
    logic [WAIT_W-1:0] wait_cnt;
    logic [2:0]        idx, next_idx;
    logic              second;
    logic [15:0]       snap;
    logic              tx_start, tx_rs, tx_done;
    logic [3:0]        tx_nib;

    logic [7:0]        cur_byte;
    logic              cur_rs, is_byte;
    logic [3:0]        send_nib;
    int                post_wait, wait_len;
    logic              wait_hit;

    assign lcd_rw = 1'b0;

    // What the current state sends and how long to wait afterwards
    always_comb begin
        cur_byte  = 8'h00;
        cur_rs    = 1'b0;
        is_byte   = 1'b1;
        post_wait = BYTE_WAIT_CYCLES;
        case (state)
            ST_INIT_A: begin cur_byte = 8'h03; is_byte = 1'b0; post_wait = INIT_WAIT1_CYCLES; end
            ST_INIT_B: begin cur_byte = 8'h03; is_byte = 1'b0; post_wait = INIT_WAIT2_CYCLES; end
            ST_INIT_C: begin cur_byte = 8'h03; is_byte = 1'b0; end
            ST_INIT_D: begin cur_byte = 8'h02; is_byte = 1'b0; end
            ST_CFG: begin
                case (idx[1:0])
                    2'd0:    cur_byte = FUNC_SET_4BIT;
                    2'd1:    cur_byte = ENTRY_MODE;
                    2'd2:    cur_byte = DISP_ON;
                    default: cur_byte = CLEAR;
                endcase
            end
            ST_FRAME_ADDR: cur_byte = DDRAM_LINE1;
            ST_FRAME_CHAR: begin
                cur_rs = 1'b1;
                case (idx)
                    3'd0:    cur_byte = CHAR_P;
                    3'd1:    cur_byte = CHAR_C;
                    3'd2:    cur_byte = CHAR_EQ;
                    3'd3:    cur_byte = hex_ascii(snap[15:12]);
                    3'd4:    cur_byte = hex_ascii(snap[11:8]);
                    3'd5:    cur_byte = hex_ascii(snap[7:4]);
                    default: cur_byte = hex_ascii(snap[3:0]);
                endcase
            end
            default: ;
        endcase
    end

    assign send_nib = (is_byte && !second) ? cur_byte[7:4] : cur_byte[3:0];

    // Single wait counter is shared: only one wait is ever active at a time
    always_comb begin
        case (state)
            ST_PWRUP:    wait_len = POWERUP_CYCLES;
            ST_CLR_WAIT: wait_len = CLEAR_WAIT_CYCLES;
            ST_IDLE:     wait_len = REFRESH_CYCLES;
            default:     wait_len = (sub == SUB_GAP) ? NIBBLE_GAP_CYCLES : post_wait;
        endcase
    end

    assign wait_hit = (int'(wait_cnt) + 1) >= wait_len;

    // Successor once the current send step and its wait are complete
    always_comb begin
        next_state = state;
        next_idx   = idx;
        case (state)
            ST_INIT_A: next_state = ST_INIT_B;
            ST_INIT_B: next_state = ST_INIT_C;
            ST_INIT_C: next_state = ST_INIT_D;
            ST_INIT_D: begin next_state = ST_CFG; next_idx = 3'd0; end
            ST_CFG: begin
                if (idx == 3'd3) begin next_state = ST_CLR_WAIT; next_idx = 3'd0; end
                else next_idx = idx + 3'd1;
            end
            ST_FRAME_ADDR: begin next_state = ST_FRAME_CHAR; next_idx = 3'd0; end
            ST_FRAME_CHAR: begin
                if (idx == 3'd6) begin next_state = ST_IDLE; next_idx = 3'd0; end
                else next_idx = idx + 3'd1;
            end
            default: ;
        endcase
    end

    // Main sequencer: init once, then snapshot pc_in and redraw every refresh period
    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_PWRUP;
            sub       <= SUB_START;
            wait_cnt  <= '0;
            idx       <= 3'd0;
            second    <= 1'b0;
            snap      <= 16'h0000;
            init_done <= 1'b0;
            tx_start  <= 1'b0;
            tx_nib    <= 4'h0;
            tx_rs     <= 1'b0;
        end else begin
            tx_start <= 1'b0;
            case (state)
                ST_PWRUP: begin
                    if (wait_hit) begin wait_cnt <= '0; state <= ST_INIT_A; end
                    else wait_cnt <= wait_cnt + WAIT_W'(1);
                end
                ST_CLR_WAIT: begin
                    if (wait_hit) begin
                        wait_cnt  <= '0;
                        init_done <= 1'b1;
                        snap      <= pc_in;
                        state     <= ST_FRAME_ADDR;
                    end else wait_cnt <= wait_cnt + WAIT_W'(1);
                end
                ST_IDLE: begin
                    if (wait_hit) begin
                        wait_cnt <= '0;
                        snap     <= pc_in;
                        state    <= ST_FRAME_ADDR;
                    end else wait_cnt <= wait_cnt + WAIT_W'(1);
                end
                default: begin
                    case (sub)
                        SUB_START: begin
                            tx_start <= 1'b1;
                            tx_nib   <= send_nib;
                            tx_rs    <= cur_rs;
                            sub      <= SUB_BUSY;
                        end
                        SUB_BUSY: begin
                            if (tx_done) begin
                                wait_cnt <= '0;
                                if (is_byte && !second) begin
                                    second <= 1'b1;
                                    sub    <= (NIBBLE_GAP_CYCLES == 0) ? SUB_START : SUB_GAP;
                                end else begin
                                    second <= 1'b0;
                                    if (post_wait == 0) begin
                                        sub   <= SUB_START;
                                        state <= next_state;
                                        idx   <= next_idx;
                                    end else sub <= SUB_POST;
                                end
                            end
                        end
                        SUB_GAP: begin
                            if (wait_hit) begin wait_cnt <= '0; sub <= SUB_START; end
                            else wait_cnt <= wait_cnt + WAIT_W'(1);
                        end
                        default: begin
                            if (wait_hit) begin
                                wait_cnt <= '0;
                                sub      <= SUB_START;
                                state    <= next_state;
                                idx      <= next_idx;
                            end else wait_cnt <= wait_cnt + WAIT_W'(1);
                        end
                    endcase
                end
            endcase
        end
    end

    apple1_lcd_nibble_tx #(
        .SETUP_CYCLES  (SETUP_CYCLES),
        .E_PULSE_CYCLES(E_PULSE_CYCLES)
    ) u_nibble_tx (
        .clk25 (clk25),
        .rst_n (rst_n),
        .start (tx_start),
        .nibble(tx_nib),
        .rs    (tx_rs),
        .lcd_e (lcd_e),
        .lcd_rs(lcd_rs),
        .lcd_d (lcd_d),
        .done  (tx_done)
    );

endmodule

// File: tb/tb_apple1_pc_lcd.sv
// tb/tb_apple1_pc_lcd.sv - scoreboard bench for the PC-to-LCD display driver
`timescale 1ns/1ps
module tb_apple1_pc_lcd;

    localparam int P_POWERUP = 50;
    localparam int P_EPULSE  = 12;
    localparam int P_REFRESH = 100;

    logic        clk25 = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] pc_in = 16'h0000;
    logic        lcd_e, lcd_rs, lcd_rw, init_done;
    logic [3:0]  lcd_d;

    always #5 clk25 = ~clk25;

    apple1_pc_lcd #(
        .POWERUP_CYCLES   (P_POWERUP),
        .INIT_WAIT1_CYCLES(20),
        .INIT_WAIT2_CYCLES(10),
        .SETUP_CYCLES     (2),
        .E_PULSE_CYCLES   (P_EPULSE),
        .NIBBLE_GAP_CYCLES(25),
        .BYTE_WAIT_CYCLES (8),
        .CLEAR_WAIT_CYCLES(15),
        .REFRESH_CYCLES   (P_REFRESH)
    ) dut (
        .clk25    (clk25),
        .rst_n    (rst_n),
        .pc_in    (pc_in),
        .lcd_e    (lcd_e),
        .lcd_rs   (lcd_rs),
        .lcd_rw   (lcd_rw),
        .lcd_d    (lcd_d),
        .init_done(init_done)
    );

    typedef struct {
        logic       done;
        logic       rs;
        logic [3:0] nib;
        logic [1:0] gap_kind;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   pops   = 0;
    logic rw_seen_high = 1'b0;

    task automatic check(input string name, input logic ok, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic push_nib(input logic d, input logic rs, input logic [3:0] n, input logic [1:0] k);
        exp_t x;
        x.done = d; x.rs = rs; x.nib = n; x.gap_kind = k;
        exp_q.push_back(x);
    endtask

    task automatic push_byte(input logic d, input logic rs, input logic [7:0] b, input logic [1:0] k);
        push_nib(d, rs, b[7:4], k);
        push_nib(d, rs, b[3:0], 2'd0);
    endtask

    task automatic push_init();
        push_nib(1'b0, 1'b0, 4'h3, 2'd2);
        push_nib(1'b0, 1'b0, 4'h3, 2'd0);
        push_nib(1'b0, 1'b0, 4'h3, 2'd0);
        push_nib(1'b0, 1'b0, 4'h2, 2'd0);
        push_byte(1'b0, 1'b0, 8'h28, 2'd0);
        push_byte(1'b0, 1'b0, 8'h06, 2'd0);
        push_byte(1'b0, 1'b0, 8'h0C, 2'd0);
        push_byte(1'b0, 1'b0, 8'h01, 2'd0);
    endtask

    task automatic push_frame(input logic [31:0] digits, input logic [1:0] k);
        push_byte(1'b1, 1'b0, 8'h80, k);
        push_byte(1'b1, 1'b1, 8'h50, 2'd0);
        push_byte(1'b1, 1'b1, 8'h43, 2'd0);
        push_byte(1'b1, 1'b1, 8'h3D, 2'd0);
        for (int i = 3; i >= 0; i--) push_byte(1'b1, 1'b1, digits[i*8 +: 8], 2'd0);
    endtask

    task automatic wait_pops(input int target, input int budget);
        int n;
        n = 0;
        while (pops < target && n < budget) begin
            @(negedge clk25);
            n++;
        end
        check("wait_pulses", pops >= target, 32'(pops), 32'(target));
    endtask

    task automatic check_quiet();
        logic seen;
        seen = 1'b0;
        repeat (P_POWERUP) begin
            @(negedge clk25);
            if (lcd_e) seen = 1'b1;
        end
        check("powerup_quiet", !seen, 32'(seen), 32'd0);
    endtask

    task automatic check_zero(input string name);
        check(name, {lcd_e, lcd_rs, lcd_rw, lcd_d, init_done} == 8'h00,
              32'({lcd_e, lcd_rs, lcd_rw, lcd_d, init_done}), 32'd0);
    endtask

    // Monitor: decode every E pulse, pop the scoreboard and check timing
    logic       e_prev = 1'b0;
    logic       have_fall = 1'b0;
    logic       changed_high = 1'b0;
    logic [4:0] last_val = 5'd0;
    logic [4:0] rise_val = 5'd0;
    int         high_len = 0;
    int         stable = 0;
    int         gap = 0;
    exp_t       cur;

    always @(negedge clk25) begin
        if (lcd_rw) rw_seen_high = 1'b1;
        if (!rst_n) begin
            e_prev = 1'b0; have_fall = 1'b0; changed_high = 1'b0;
            high_len = 0; stable = 0; gap = 0;
            last_val = {lcd_rs, lcd_d};
        end else begin
            if ({lcd_rs, lcd_d} == last_val) stable++;
            else stable = 0;
            last_val = {lcd_rs, lcd_d};
            if (lcd_e && !e_prev) begin
                pops++;
                check("setup", stable >= 2, 32'(stable), 32'd2);
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", 1'b0, 32'(last_val), 32'd0);
                end else begin
                    cur = exp_q.pop_front();
                    check("pulse_data", {init_done, lcd_rs, lcd_d} == {cur.done, cur.rs, cur.nib},
                          32'({init_done, lcd_rs, lcd_d}), 32'({cur.done, cur.rs, cur.nib}));
                    if (cur.gap_kind == 2'd1)
                        check("frame_gap_long", have_fall && gap >= P_REFRESH, 32'(gap), 32'(P_REFRESH));
                    else if (cur.gap_kind == 2'd0)
                        check("gap_short", have_fall && gap < P_REFRESH, 32'(gap), 32'(P_REFRESH));
                end
                rise_val = last_val;
                high_len = 1;
                changed_high = 1'b0;
            end else if (lcd_e) begin
                high_len++;
                if (last_val != rise_val) changed_high = 1'b1;
            end else if (e_prev) begin
                check("e_high_len", high_len == P_EPULSE, 32'(high_len), 32'(P_EPULSE));
                check("hold", !changed_high && last_val == rise_val, 32'(last_val), 32'(rise_val));
                have_fall = 1'b1;
                gap = 0;
            end
            if (!lcd_e) gap++;
            e_prev = lcd_e;
        end
    end

    // Stimulus: directed pc values, mid-frame pc change and mid-frame reset
    initial begin
        rst_n = 1'b0;
        pc_in = 16'h0000;
        #12;
        check_zero("reset_state");
        #11 rst_n = 1'b1;
        push_init();
        push_frame(32'h30303030, 2'd0);
        check_quiet();
        wait_pops(28, 4000);

        pc_in = 16'h1F2A;
        push_frame(32'h31463241, 2'd1);
        push_frame(32'h31463241, 2'd1);
        wait_pops(60, 4000);

        pc_in = 16'hFF00;
        push_frame(32'h46463030, 2'd1);
        push_frame(32'h45303030, 2'd1);
        wait_pops(68, 2000);
        pc_in = 16'hE000;
        wait_pops(92, 4000);

        push_frame(32'h45303030, 2'd1);
        wait_pops(103, 4000);
        #3 rst_n = 1'b0;
        #1 check_zero("async_reset");
        exp_q.delete();
        repeat (3) @(negedge clk25);
        #3 rst_n = 1'b1;
        push_init();
        push_frame(32'h45303030, 2'd0);
        check_quiet();
        wait_pops(131, 5000);

        check("queue_drained", exp_q.size() == 0, 32'(exp_q.size()), 32'd0);
        check("rw_low", !rw_seen_high, 32'(rw_seen_high), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
